conv_interleaver: RTL and testbench
===================================

# conv_interleaver

Parametrised Forney convolutional interleaver / deinterleaver built from per-branch register delay lines and a byte commutator. It generalises the fixed chained branch buffers of the current interleaver into a single block with configurable branch count, unit depth, data width and direction. It sits in the byte stream between the outer RS encoder and the inner coder on TX, or in mirror position on RX. It adds sync-driven commutator alignment and a fill-status flag.

## Interface

Parameters:

- WIDTH, 8, data width in bits.
- BRANCHES, 12, number of commutator branches (≥2).
- UNIT_DEPTH, 17, delay increment per branch, in branch writes (≥1).
- DEINTERLEAVE, 0. 0 sets branch b depth to b·UNIT_DEPTH. 1 sets it to (BRANCHES−1−b)·UNIT_DEPTH.

Ports:

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- buf_en  in  1  input byte valid; the byte is accepted on every clk edge where it is high.
- sync_in  in  1  qualified by buf_en; forces the current byte onto branch 0.
- data_in  in  WIDTH  input byte.
- data_out  out  WIDTH  registered output byte.
- data_valid  out  1  registered copy of buf_en.
- branch_idx  out  clog2(BRANCHES)  branch the next accepted byte will use.
- primed  out  1  high once every delay line has been completely filled.

## Operation

- Branch b holds a shift register of D(b) words, with D(b) set by DEINTERLEAVE.
- Current branch: c = 0 when sync_in=1, otherwise c = branch_idx.
- On an accepted byte (buf_en=1):
  - If D(c)=0: data_out <= data_in.
  - If D(c)>0: data_out <= oldest word of branch c; branch c shifts by one and data_in enters at the head.
  - Only branch c shifts; all other branches hold.
- Commutator: on accept, branch_idx <= (c==BRANCHES−1) ? 0 : c+1.
  - sync_in=1 with buf_en=1 therefore leaves branch_idx=1.
  - sync_in without buf_en is ignored.
- buf_en=0: data_out, branch_idx and all delay lines hold; data_valid <= 0.
- Fill counter:
  - Counts accepted bytes and saturates at FILL = BRANCHES·(BRANCHES−1)·UNIT_DEPTH (defaults: 2244).
  - Width is clog2(FILL+1).
  - primed <= 1 when the count reaches FILL. It stays high until reset; sync_in does not clear it.
- Before primed, output words from unfilled lines are the reset value 0 and are still flagged data_valid.
- An interleaver and deinterleaver with equal parameters in cascade restore the original stream. Output byte k equals input byte k − FILL, counted in accepted bytes.

## Timing

- Reset values: data_out=0, data_valid=0, branch_idx=0, primed=0, fill count=0, every delay-line word=0.
- Reset asserted mid-stream clears everything immediately, without waiting for a clock edge. The first accepted byte after release goes to branch 0.
- Register latency is 1 cycle: a byte accepted at edge n appears with data_valid at edge n+1.
- Branch-delay latency is D(b) further accepts on the same branch, i.e. D(b)·BRANCHES accepted bytes under continuous traffic.
- Gaps in buf_en add no data corruption; only accepted bytes advance the structure.
- Continuous buf_en gives one byte per cycle, with no backpressure and no stall.

## Test plan

1. **Reset state.** Defaults; hold reset, then release with buf_en=0 → data_out=0, data_valid=0, branch_idx=0, primed=0 throughout.
2. **Small interleaver.** BRANCHES=3, UNIT_DEPTH=2, DEINTERLEAVE=0; feed 1,2,3,… continuously from reset. Required response:
   - Branch 0 outputs its byte one cycle later: 1 appears at cycle 1, 4 at cycle 4.
   - Branch 1 outputs 2 at its third visit.
   - Branch 2 outputs 3 at its fifth visit.
   - primed rises on the 12th accept.
3. **Loopback.** Default interleaver feeding a default deinterleaver; send 5000 random bytes with random buf_en gaps → the deinterleaver's valid output byte k equals input byte k−2244 for all k ≥ 2244.
4. **Sync realignment.** Defaults; drive sync_in=1 with buf_en=1 while branch_idx=7 → the byte is routed to branch 0 (zero delay, appears next cycle) and branch_idx=1 afterwards. Drive sync_in=1 with buf_en=0 → no change.
5. **Stall hold.** Drop buf_en for 10 cycles mid-stream → data_out, branch_idx and the fill count are frozen and data_valid=0. On resume the output sequence continues as if uninterrupted.
6. **Reset mid-operation.** Assert reset after 3000 bytes (primed=1) → all outputs return to 0 asynchronously. After release, the delay lines read zeros and primed re-asserts only after a further 2244 accepts.

Source files
------------

// File: rtl/conv_interleaver.sv
// Forney convolutional interleaver/deinterleaver: per-branch shift-register delay
// lines selected by a byte commutator, with sync realignment and a fill flag.
module conv_interleaver #(
  parameter int WIDTH        = 8,
  parameter int BRANCHES     = 12,
  parameter int UNIT_DEPTH   = 17,
  parameter int DEINTERLEAVE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        buf_en,
  input  logic                        sync_in,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            data_out,
  output logic                        data_valid,
  output logic [$clog2(BRANCHES)-1:0] branch_idx,
  output logic                        primed
);

  localparam int IDX_W = $clog2(BRANCHES);
  localparam int FILL  = BRANCHES * (BRANCHES - 1) * UNIT_DEPTH;
  localparam int CNT_W = $clog2(FILL + 1);
  localparam logic [CNT_W-1:0] FILL_C = CNT_W'(FILL);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(BRANCHES - 1);

  function automatic int depth_f(input int b);
    return (DEINTERLEAVE != 0) ? (BRANCHES - 1 - b) * UNIT_DEPTH : b * UNIT_DEPTH;
  endfunction

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [IDX_W-1:0] branch_idx_q, branch_idx_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             primed_q, primed_d;

  logic [IDX_W-1:0]                 cur_s;
  logic [BRANCHES-1:0][WIDTH-1:0]   tap_s;
  logic [WIDTH-1:0]                 oldest_s;

  // Sync forces the current byte onto branch 0 regardless of the commutator.
  always_comb begin
    if (sync_in) begin
      cur_s = {IDX_W{1'b0}};
    end else begin
      cur_s = branch_idx_q;
    end
  end

  for (genvar b = 0; b < BRANCHES; b++) begin : g_branch
    localparam int D = depth_f(b);
    logic sel_s;
    assign sel_s = buf_en && (cur_s == IDX_W'(b));

    if (D == 0) begin : g_pass
      assign tap_s[b] = data_in;
    end else begin : g_line
      logic [WIDTH-1:0] line_q [D];
      logic [WIDTH-1:0] line_d [D];

      // Shift this line only when its branch is the one being served.
      always_comb begin
        if (sel_s) begin
          line_d[0] = data_in;
          for (int i = 1; i < D; i++) begin
            line_d[i] = line_q[i-1];
          end
        end else begin
          for (int i = 0; i < D; i++) begin
            line_d[i] = line_q[i];
          end
        end
      end

      // Delay-line storage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) begin
            line_q[i] <= {WIDTH{1'b0}};
          end
        end else begin
          for (int i = 0; i < D; i++) begin
            line_q[i] <= line_d[i];
          end
        end
      end

      assign tap_s[b] = line_q[D-1];
    end
  end

  // Oldest word of the current branch (or the input itself for a zero-depth branch).
  always_comb begin
    oldest_s = {WIDTH{1'b0}};
    for (int b = 0; b < BRANCHES; b++) begin
      if (cur_s == IDX_W'(b)) begin
        oldest_s = tap_s[b];
      end else begin
        oldest_s = oldest_s;
      end
    end
  end

  // Output register, commutator advance and saturating fill counter.
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    branch_idx_d = branch_idx_q;
    fill_d       = fill_q;
    primed_d     = primed_q;
    if (buf_en) begin
      data_out_d   = oldest_s;
      data_valid_d = 1'b1;
      if (cur_s == LAST_C) begin
        branch_idx_d = {IDX_W{1'b0}};
      end else begin
        branch_idx_d = cur_s + IDX_W'(1'b1);
      end
      if (fill_q != FILL_C) begin
        fill_d = fill_q + CNT_W'(1'b1);
      end else begin
        fill_d = fill_q;
      end
      primed_d = primed_q | (fill_d == FILL_C);
    end else begin
      data_valid_d = 1'b0;
    end
  end

  // Control and output state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= {WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      branch_idx_q <= {IDX_W{1'b0}};
      fill_q       <= {CNT_W{1'b0}};
      primed_q     <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      branch_idx_q <= branch_idx_d;
      fill_q       <= fill_d;
      primed_q     <= primed_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign branch_idx = branch_idx_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// Randomized bench for conv_interleaver: per-branch history model for the default
// interleaver, closed-form expectations for a small instance, and a loopback pair.
module tb_conv_interleaver;

  localparam int W     = 8;
  localparam int BR    = 12;
  localparam int UD    = 17;
  localparam int FILL  = BR * (BR - 1) * UD;
  localparam int HDEP  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en, sync;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         dvalid;
  logic [3:0]   didx;
  logic         dprimed;

  logic [W-1:0] ddout;
  logic         ddvalid;
  logic [3:0]   ddidx;
  logic         ddprimed;

  logic         s_en, s_sync;
  logic [W-1:0] s_din;
  logic [W-1:0] s_dout;
  logic         s_dvalid;
  logic [1:0]   s_idx;
  logic         s_primed;

  conv_interleaver #(.WIDTH(W), .BRANCHES(BR), .UNIT_DEPTH(UD), .DEINTERLEAVE(0)) dut (
    .clk(clk), .reset(rst), .buf_en(en), .sync_in(sync), .data_in(din),
    .data_out(dout), .data_valid(dvalid), .branch_idx(didx), .primed(dprimed));

  conv_interleaver #(.WIDTH(W), .BRANCHES(BR), .UNIT_DEPTH(UD), .DEINTERLEAVE(1)) dut_deint (
    .clk(clk), .reset(rst), .buf_en(dvalid), .sync_in(1'b0), .data_in(dout),
    .data_out(ddout), .data_valid(ddvalid), .branch_idx(ddidx), .primed(ddprimed));

  conv_interleaver #(.WIDTH(W), .BRANCHES(3), .UNIT_DEPTH(2), .DEINTERLEAVE(0)) dut_small (
    .clk(clk), .reset(rst), .buf_en(s_en), .sync_in(s_sync), .data_in(s_din),
    .data_out(s_dout), .data_valid(s_dvalid), .branch_idx(s_idx), .primed(s_primed));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each branch is a history of the bytes written to it;
  // a depth-D branch returns the byte written D visits earlier (0 if none).
  int           visits [BR];
  logic [W-1:0] hist   [BR][HDEP];
  int           m_idx;
  int           m_fill;
  bit           m_primed;
  logic [W-1:0] exp_out;
  bit           exp_valid;

  task automatic model_clear();
    for (int b = 0; b < BR; b++) visits[b] = 0;
    m_idx = 0; m_fill = 0; m_primed = 1'b0;
    exp_out = 8'd0; exp_valid = 1'b0;
  endtask

  task automatic step(input bit e, input bit s, input logic [W-1:0] d);
    int c, v, dp;
    en = e; sync = s; din = d;
    @(posedge clk);
    if (e) begin
      c  = s ? 0 : m_idx;
      v  = visits[c];
      dp = c * UD;
      hist[c][v] = d;
      exp_out = (v >= dp) ? hist[c][v - dp] : 8'd0;
      visits[c] = v + 1;
      m_idx = (c + 1) % BR;
      if (m_fill < FILL) m_fill = m_fill + 1;
      if (m_fill == FILL) m_primed = 1'b1;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0; sync = 1'b0; din = 8'd0;
    s_en = 1'b0; s_sync = 1'b0; s_din = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b0; sync = 1'b0; din = 8'd0;
    s_en = 1'b0; s_sync = 1'b0; s_din = 8'd0;
    rst = 1'b1;
    #12;
    vectors++;
    if ({dout, dvalid, didx, dprimed} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_hold got out=%0d v=%0d idx=%0d p=%0d exp all 0", dout, dvalid, didx, dprimed);
    end
    #5;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 8'h00);
      vectors++;
      if ({dout, dvalid, didx, dprimed} !== 14'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got out=%0d v=%0d idx=%0d p=%0d exp all 0", i, dout, dvalid, didx, dprimed);
      end
      vectors++;
      if ({s_dout, s_dvalid, s_idx, s_primed} !== 12'd0) begin
        miscompares++;
        $display("FAIL reset_small cyc=%0d got out=%0d v=%0d idx=%0d p=%0d exp all 0", i, s_dout, s_dvalid, s_idx, s_primed);
      end
    end
  endtask

  task automatic test_small();
    int b, v, dp, e;
    apply_reset();
    for (int n = 1; n <= 24; n++) begin
      s_en = 1'b1; s_din = W'(n);
      @(posedge clk);
      #1;
      b = (n - 1) % 3; v = (n - 1) / 3; dp = b * 2;
      e = (v >= dp) ? n - dp * 3 : 0;
      vectors++;
      if (s_dout !== W'(e) || s_dvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL small_out n=%0d got=%0d/%0d exp=%0d/1", n, s_dout, s_dvalid, e);
      end
      vectors++;
      if (s_idx !== 2'(n % 3)) begin
        miscompares++;
        $display("FAIL small_idx n=%0d got=%0d exp=%0d", n, s_idx, n % 3);
      end
      vectors++;
      if (s_primed !== (n >= 12)) begin
        miscompares++;
        $display("FAIL small_primed n=%0d got=%0d exp=%0d", n, s_primed, (n >= 12));
      end
    end
    s_en = 1'b0;
  endtask

  task automatic test_loopback();
    logic [W-1:0] in_hist [8192];
    int acc, outk, cyc;
    bit e;
    logic [W-1:0] d;
    apply_reset();
    acc = 0; outk = 0; cyc = 0;
    while (acc < 5000 && cyc < 20000) begin
      e = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      step(e, 1'b0, d);
      cyc++;
      if (e) begin
        in_hist[acc] = d;
        acc++;
      end
      vectors++;
      if (dvalid !== exp_valid || (exp_valid && dout !== exp_out)) begin
        miscompares++;
        $display("FAIL loop_int cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, dout, dvalid, exp_out, exp_valid);
      end
      if (ddvalid) begin
        if (outk >= FILL) begin
          vectors++;
          if (ddout !== in_hist[outk - FILL]) begin
            miscompares++;
            $display("FAIL loop_deint k=%0d got=%0d exp=%0d", outk, ddout, in_hist[outk - FILL]);
          end
        end
        outk++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (ddvalid) begin
        vectors++;
        if (ddout !== in_hist[outk - FILL]) begin
          miscompares++;
          $display("FAIL loop_deint k=%0d got=%0d exp=%0d", outk, ddout, in_hist[outk - FILL]);
        end
        outk++;
      end
    end
    vectors++;
    if (acc != 5000 || outk != 5000) begin
      miscompares++;
      $display("FAIL loop_count got acc=%0d out=%0d exp 5000/5000", acc, outk);
    end
  endtask

  task automatic test_sync();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out) begin
        miscompares++;
        $display("FAIL sync_pre i=%0d got=%0d exp=%0d", i, dout, exp_out);
      end
    end
    vectors++;
    if (didx !== 4'd7) begin
      miscompares++;
      $display("FAIL sync_idx7 got=%0d exp=7", didx);
    end
    step(1'b1, 1'b1, 8'hA5);
    vectors++;
    if (dout !== 8'hA5 || didx !== 4'd1 || dvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL sync_route got out=%0h idx=%0d v=%0d exp a5/1/1", dout, didx, dvalid);
    end
    step(1'b0, 1'b1, 8'h3C);
    vectors++;
    if (dout !== 8'hA5 || didx !== 4'd1 || dvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_noen got out=%0h idx=%0d v=%0d exp a5/1/0", dout, didx, dvalid);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out || didx !== 4'(m_idx)) begin
        miscompares++;
        $display("FAIL sync_post i=%0d got=%0d/%0d exp=%0d/%0d", i, dout, didx, exp_out, m_idx);
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out || didx !== 4'(m_idx)) begin
        miscompares++;
        $display("FAIL stall_pre i=%0d got=%0d/%0d exp=%0d/%0d", i, dout, didx, exp_out, m_idx);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'($urandom), W'($urandom));
      vectors++;
      if (dout !== exp_out || didx !== 4'(m_idx) || dvalid !== 1'b0 || dut.fill_q !== 12'(m_fill)) begin
        miscompares++;
        $display("FAIL stall_hold i=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/0/%0d",
                 i, dout, didx, dvalid, dut.fill_q, exp_out, m_idx, m_fill);
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out || didx !== 4'(m_idx) || dvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_resume i=%0d got=%0d/%0d exp=%0d/%0d", i, dout, didx, exp_out, m_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out || dprimed !== m_primed) begin
        miscompares++;
        $display("FAIL mid_run i=%0d got=%0d/%0d exp=%0d/%0d", i, dout, dprimed, exp_out, m_primed);
      end
    end
    vectors++;
    if (dprimed !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_primed got=%0d exp=1", dprimed);
    end
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({dout, dvalid, didx, dprimed} !== 14'd0) begin
      miscompares++;
      $display("FAIL mid_async got out=%0d v=%0d idx=%0d p=%0d exp all 0", dout, dvalid, didx, dprimed);
    end
    #2;
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < FILL + 20; i++) begin
      step(1'b1, 1'b0, W'($urandom));
      vectors++;
      if (dout !== exp_out) begin
        miscompares++;
        $display("FAIL mid_refill i=%0d got=%0d exp=%0d", i, dout, exp_out);
      end
      vectors++;
      if (dprimed !== (i + 1 >= FILL)) begin
        miscompares++;
        $display("FAIL mid_reprime i=%0d got=%0d exp=%0d", i, dprimed, (i + 1 >= FILL));
      end
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_loopback();
    test_sync();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
